aes_round_ctrl: RTL and testbench

//  Round sequencer for the byte-serial AES-128/192/256 encrypt datapath.
//  - Accepts one 16-byte block; runs the initial AddRoundKey, then NR rounds.
//  - Each round streams 16 bytes through subbytes -> shiftrows -> mixcolumns -> addroundkey.
//  - Drives the per-stage enables, byte/round indices, round-key fetch handshake and output handshake.

---
 rtl/aes_round_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the byte-serial AES-128/192/256 encrypt datapath.
// Defining AES_CTRL_ABORT_EN adds the abort_i / aborted_o block-abort feature.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  output logic       busy_o,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       key_req_o,
  input  logic       key_ack_i,
  input  logic       sr_ready_i,
  output logic [3:0] round_o,
  output logic [3:0] byte_idx_o,
  output logic       sb_en_o,
  output logic       sr_en_o,
  output logic       mc_en_o,
  output logic       ark_en_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
`ifdef AES_CTRL_ABORT_EN
  input  logic       abort_i,
  output logic       aborted_o,
`endif
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KREQ,
    ROUND,
    DRAIN,
    OUT
  } state_e;

  localparam logic [3:0] LastRound = 4'(NR);
  localparam logic [3:0] LastByte  = 4'd15;

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] idx_q,   idx_d;
  logic       done_q,  done_d;
`ifdef AES_CTRL_ABORT_EN
  logic       aborted_q, aborted_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      round_q   <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
`ifdef AES_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
`ifdef AES_CTRL_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    aborted_d   = 1'b0;
`endif
    in_ready_o  = 1'b0;
    key_req_o   = 1'b0;
    sb_en_o     = 1'b0;
    sr_en_o     = 1'b0;
    mc_en_o     = 1'b0;
    ark_en_o    = 1'b0;
    out_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_q marks the cycle right after completion; a start there is dropped
        if (start_i && !done_q) begin
          state_d = LOAD;
          round_d = '0;
          idx_d   = '0;
        end
      end

      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          ark_en_o = 1'b1;
          if (idx_q == LastByte) begin
            state_d = KREQ;
            round_d = 4'd1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      KREQ: begin
        key_req_o = 1'b1;
        if (key_ack_i) begin
          state_d = ROUND;
          idx_d   = '0;
        end
      end

      ROUND: begin
        sb_en_o  = 1'b1;
        sr_en_o  = 1'b1;
        ark_en_o = 1'b1;
        mc_en_o  = (round_q != LastRound);
        if (idx_q == LastByte) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      DRAIN: begin
        if (sr_ready_i) begin
          if (round_q == LastRound) begin
            state_d = OUT;
            idx_d   = '0;
          end else begin
            state_d = KREQ;
            round_d = round_q + 4'd1;
          end
        end
      end

      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (idx_q == LastByte) begin
            state_d = IDLE;
            round_d = '0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        round_d = '0;
        idx_d   = '0;
      end
    endcase

`ifdef AES_CTRL_ABORT_EN
    // Abort overrides whatever transition the current state selected
    if (abort_i && (state_q != IDLE)) begin
      state_d   = IDLE;
      round_d   = '0;
      idx_d     = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  assign busy_o     = (state_q != IDLE);
  assign round_o    = round_q;
  assign byte_idx_o = idx_q;
  assign done_o     = done_q;
`ifdef AES_CTRL_ABORT_EN
  assign aborted_o  = aborted_q;
`endif

  a_round_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    round_q <= LastRound);
  a_done_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> (state_q == IDLE));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: NR=10 and NR=14 instances share stimulus
// and are checked every cycle against a phase-level reference model plus spec cycle counts.
module tb_aes_round_ctrl;

  localparam int NI = 2;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_KEY = 2, PH_RND = 3, PH_DRN = 4, PH_OUT = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i, in_valid_i, key_ack_i, sr_ready_i, out_ready_i;
  logic [NI-1:0] busy_o, in_ready_o, key_req_o, sb_en_o, sr_en_o, mc_en_o, ark_en_o;
  logic [NI-1:0] out_valid_o, done_o;
  logic [3:0] round_o [NI];
  logic [3:0] byte_idx_o [NI];
`ifdef AES_CTRL_ABORT_EN
  logic abort_i;
  logic [NI-1:0] aborted_o;
`endif

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o[0]),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o[0]), .key_req_o(key_req_o[0]),
    .key_ack_i(key_ack_i), .sr_ready_i(sr_ready_i), .round_o(round_o[0]),
    .byte_idx_o(byte_idx_o[0]), .sb_en_o(sb_en_o[0]), .sr_en_o(sr_en_o[0]),
    .mc_en_o(mc_en_o[0]), .ark_en_o(ark_en_o[0]), .out_valid_o(out_valid_o[0]),
    .out_ready_i(out_ready_i),
`ifdef AES_CTRL_ABORT_EN
    .abort_i(abort_i), .aborted_o(aborted_o[0]),
`endif
    .done_o(done_o[0])
  );

  aes_round_ctrl #(.NR(14)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o[1]),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o[1]), .key_req_o(key_req_o[1]),
    .key_ack_i(key_ack_i), .sr_ready_i(sr_ready_i), .round_o(round_o[1]),
    .byte_idx_o(byte_idx_o[1]), .sb_en_o(sb_en_o[1]), .sr_en_o(sr_en_o[1]),
    .mc_en_o(mc_en_o[1]), .ark_en_o(ark_en_o[1]), .out_valid_o(out_valid_o[1]),
    .out_ready_i(out_ready_i),
`ifdef AES_CTRL_ABORT_EN
    .abort_i(abort_i), .aborted_o(aborted_o[1]),
`endif
    .done_o(done_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state
  int nr_of [NI] = '{10, 14};
  int m_ph [NI];
  int m_rnd [NI];
  int m_idx [NI];
  bit m_done [NI];
  bit m_abt [NI];

  // statistics gathered from DUT outputs
  int sb_cnt [NI], mc_cnt [NI], sb_last [NI], mc_last [NI], ark_ld [NI];
  int kreq_r2 [NI], en_kreq [NI], max_rnd [NI], done_cnt [NI], done_at [NI];
  int ov_cnt [NI], ld_idx4 [NI];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_ph[i] = PH_IDLE; m_rnd[i] = 0; m_idx[i] = 0; m_done[i] = 0; m_abt[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit was_done;
    bit ab;
    was_done = m_done[i];
    m_done[i] = 0;
    m_abt[i] = 0;
    ab = 0;
`ifdef AES_CTRL_ABORT_EN
    ab = abort_i && (m_ph[i] != PH_IDLE);
`endif
    if (ab) begin
      m_ph[i] = PH_IDLE; m_rnd[i] = 0; m_idx[i] = 0; m_abt[i] = 1;
    end else begin
      case (m_ph[i])
        PH_IDLE: if (start_i && !was_done) begin
          m_ph[i] = PH_LOAD; m_rnd[i] = 0; m_idx[i] = 0;
        end
        PH_LOAD: if (in_valid_i) begin
          if (m_idx[i] == 15) begin m_ph[i] = PH_KEY; m_rnd[i] = 1; m_idx[i] = 0; end
          else m_idx[i]++;
        end
        PH_KEY: if (key_ack_i) begin m_ph[i] = PH_RND; m_idx[i] = 0; end
        PH_RND: begin
          if (m_idx[i] == 15) begin m_ph[i] = PH_DRN; m_idx[i] = 0; end
          else m_idx[i]++;
        end
        PH_DRN: if (sr_ready_i) begin
          if (m_rnd[i] == nr_of[i]) begin m_ph[i] = PH_OUT; m_idx[i] = 0; end
          else begin m_ph[i] = PH_KEY; m_rnd[i]++; end
        end
        PH_OUT: if (out_ready_i) begin
          if (m_idx[i] == 15) begin
            m_ph[i] = PH_IDLE; m_idx[i] = 0; m_rnd[i] = 0; m_done[i] = 1;
          end else m_idx[i]++;
        end
        default: m_ph[i] = PH_IDLE;
      endcase
    end
  endtask

  task automatic check_model(input int i);
    string p;
    bit rnd_ph;
    p = (i == 0) ? "nr10" : "nr14";
    rnd_ph = (m_ph[i] == PH_RND);
    chk($sformatf("%s.busy", p), int'(busy_o[i]), int'(m_ph[i] != PH_IDLE));
    chk($sformatf("%s.in_ready", p), int'(in_ready_o[i]), int'(m_ph[i] == PH_LOAD));
    chk($sformatf("%s.key_req", p), int'(key_req_o[i]), int'(m_ph[i] == PH_KEY));
    chk($sformatf("%s.sb_en", p), int'(sb_en_o[i]), int'(rnd_ph));
    chk($sformatf("%s.sr_en", p), int'(sr_en_o[i]), int'(rnd_ph));
    chk($sformatf("%s.mc_en", p), int'(mc_en_o[i]), int'(rnd_ph && (m_rnd[i] != nr_of[i])));
    chk($sformatf("%s.ark_en", p), int'(ark_en_o[i]),
        int'(rnd_ph || (m_ph[i] == PH_LOAD && in_valid_i)));
    chk($sformatf("%s.out_valid", p), int'(out_valid_o[i]), int'(m_ph[i] == PH_OUT));
    chk($sformatf("%s.done", p), int'(done_o[i]), int'(m_done[i]));
    chk($sformatf("%s.round", p), int'(round_o[i]), m_rnd[i]);
    chk($sformatf("%s.byte_idx", p), int'(byte_idx_o[i]), m_idx[i]);
`ifdef AES_CTRL_ABORT_EN
    chk($sformatf("%s.aborted", p), int'(aborted_o[i]), int'(m_abt[i]));
`endif
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NI; i++) begin
      sb_cnt[i] = 0; mc_cnt[i] = 0; sb_last[i] = 0; mc_last[i] = 0; ark_ld[i] = 0;
      kreq_r2[i] = 0; en_kreq[i] = 0; max_rnd[i] = 0; done_cnt[i] = 0; done_at[i] = -1;
      ov_cnt[i] = 0; ld_idx4[i] = 0;
    end
  endtask

  // Sample on the falling edge: compare against the model and collect statistics.
  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_model(i);
      if (sb_en_o[i]) sb_cnt[i]++;
      if (mc_en_o[i]) mc_cnt[i]++;
      if (sb_en_o[i] && int'(round_o[i]) == nr_of[i]) sb_last[i]++;
      if (mc_en_o[i] && int'(round_o[i]) == nr_of[i]) mc_last[i]++;
      if (in_ready_o[i] && ark_en_o[i]) ark_ld[i]++;
      if (in_ready_o[i] && byte_idx_o[i] == 4'd4) ld_idx4[i]++;
      if (key_req_o[i] && round_o[i] == 4'd2) kreq_r2[i]++;
      if (key_req_o[i] && (sb_en_o[i] || sr_en_o[i] || mc_en_o[i] || ark_en_o[i])) en_kreq[i]++;
      if (out_valid_o[i]) ov_cnt[i]++;
      if (int'(round_o[i]) > max_rnd[i]) max_rnd[i] = int'(round_o[i]);
      if (done_o[i]) begin
        done_cnt[i]++;
        if (done_at[i] < 0) done_at[i] = cyc;
      end
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < NI; i++) model_step(i);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle_inputs();
    start_i = 0; in_valid_i = 0; key_ack_i = 0; sr_ready_i = 0; out_ready_i = 0;
`ifdef AES_CTRL_ABORT_EN
    abort_i = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    sample();
    advance();
    rst_n = 1;
    clear_stats();
  endtask

  // Directed block: optional LOAD stall at idx 4, key-ack delay in round 2,
  // output stall at idx 15, and start_i pulses during OUT / the done cycle.
  task automatic run_block(input int ld_len, input int ak_len, input int os_len,
                           input bit start_out, input bit stop_r3, input int wait_inst,
                           output int start_cyc);
    int ld_left, ak_left, os_left, budget;
    bit first;
    ld_left = ld_len; ak_left = ak_len; os_left = os_len; budget = 0; first = 1;
    start_cyc = cyc;
    while (done_at[wait_inst] < 0) begin
      if (stop_r3 && m_ph[0] == PH_RND && m_rnd[0] == 3 && m_idx[0] == 7) break;
      if (budget > 2000) begin fail_now("run_block.timeout"); break; end
      budget++;
      start_i = first || (start_out && (m_ph[0] == PH_OUT || m_done[0]));
      in_valid_i = 1; key_ack_i = 1; sr_ready_i = 1; out_ready_i = 1;
      if (m_ph[0] == PH_LOAD && m_idx[0] == 4 && ld_left > 0) begin in_valid_i = 0; ld_left--; end
      if (m_ph[0] == PH_KEY && m_rnd[0] == 2 && ak_left > 0) begin key_ack_i = 0; ak_left--; end
      if (m_ph[0] == PH_OUT && m_idx[0] == 15 && os_left > 0) begin out_ready_i = 0; os_left--; end
      first = 0;
      tick();
    end
  endtask

  typedef struct {
    bit st; bit iv;
    bit busy; bit rdy; bit ark; bit kreq; int idx; int rnd;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    int sc;

    // vectors for the start + LOAD phase with a 3-cycle in_valid gap at idx 4
    tbl.push_back('{st:1, iv:0, busy:0, rdy:0, ark:0, kreq:0, idx:0, rnd:0});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{st:0, iv:1, busy:1, rdy:1, ark:1, kreq:0, idx:k, rnd:0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{st:0, iv:0, busy:1, rdy:1, ark:0, kreq:0, idx:4, rnd:0});
    for (int k = 4; k < 16; k++)
      tbl.push_back('{st:0, iv:1, busy:1, rdy:1, ark:1, kreq:0, idx:k, rnd:0});
    tbl.push_back('{st:0, iv:1, busy:1, rdy:0, ark:0, kreq:1, idx:0, rnd:1});

    clear_stats();
    do_reset();
    chk("reset.busy", int'(busy_o[0]), 0);
    chk("reset.byte_idx", int'(byte_idx_o[0]), 0);

    // full no-stall block on both instances
    run_block(0, 0, 0, 0, 0, 1, sc);
    chk("nostall.nr10.latency", done_at[0] - sc, 1 + 16 + 10 * 18 + 16);
    chk("nostall.nr14.latency", done_at[1] - sc, 1 + 16 + 14 * 18 + 16);
    chk("nostall.nr10.sb_cycles", sb_cnt[0], 160);
    chk("nostall.nr10.mc_cycles", mc_cnt[0], 144);
    chk("nostall.nr14.sb_cycles", sb_cnt[1], 224);
    chk("nostall.nr14.mc_cycles", mc_cnt[1], 208);
    chk("nostall.nr14.max_round", max_rnd[1], 14);
    chk("nostall.nr14.sb_last_round", sb_last[1], 16);
    chk("nostall.nr14.mc_last_round", mc_last[1], 0);
    chk("nostall.nr10.done_pulses", done_cnt[0], 1);
    chk("nostall.nr10.out_cycles", ov_cnt[0], 16);
    chk("nostall.nr10.load_ark", ark_ld[0], 16);

    // table-driven LOAD phase
    do_reset();
    foreach (tbl[n]) begin
      start_i = tbl[n].st; in_valid_i = tbl[n].iv;
      key_ack_i = 0; sr_ready_i = 0; out_ready_i = 0;
      sample();
      chk($sformatf("tbl[%0d].busy", n), int'(busy_o[0]), int'(tbl[n].busy));
      chk($sformatf("tbl[%0d].in_ready", n), int'(in_ready_o[0]), int'(tbl[n].rdy));
      chk($sformatf("tbl[%0d].ark_en", n), int'(ark_en_o[0]), int'(tbl[n].ark));
      chk($sformatf("tbl[%0d].key_req", n), int'(key_req_o[0]), int'(tbl[n].kreq));
      chk($sformatf("tbl[%0d].byte_idx", n), int'(byte_idx_o[0]), tbl[n].idx);
      chk($sformatf("tbl[%0d].round", n), int'(round_o[0]), tbl[n].rnd);
      advance();
    end

    // stalls in LOAD, KREQ (round 2) and OUT, start_i during OUT and done
    do_reset();
    run_block(3, 5, 4, 1, 0, 0, sc);
    chk("stall.latency", done_at[0] - sc, 213 + 3 + 5 + 4);
    chk("stall.load_ark", ark_ld[0], 16);
    chk("stall.load_idx4_cycles", ld_idx4[0], 4);
    chk("stall.nr10.kreq_r2", kreq_r2[0], 6);
    chk("stall.nr14.kreq_r2", kreq_r2[1], 6);
    chk("stall.enables_in_kreq", en_kreq[0], 0);
    chk("stall.out_cycles", ov_cnt[0], 20);
    chk("stall.done_pulses", done_cnt[0], 1);
    chk("stall.start_at_done_ignored", int'(busy_o[0]), 0);
    start_i = 1;
    tick();
    start_i = 0;
    chk("stall.start_after_done_taken", int'(busy_o[0]), 1);

    // asynchronous reset in round 3, idx 7
    do_reset();
    run_block(0, 0, 0, 0, 1, 0, sc);
    chk("rst.pre.round", int'(round_o[0]), 3);
    chk("rst.pre.byte_idx", int'(byte_idx_o[0]), 7);
    rst_n = 0;
    model_reset();
    #1;
    chk("rst.busy", int'(busy_o[0]), 0);
    chk("rst.sb_en", int'(sb_en_o[0]), 0);
    chk("rst.ark_en", int'(ark_en_o[0]), 0);
    chk("rst.round", int'(round_o[0]), 0);
    chk("rst.byte_idx", int'(byte_idx_o[0]), 0);
    chk("rst.done", int'(done_o[0]), 0);
    sample();
    advance();
    rst_n = 1;
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();
    chk("rst.no_done_after", done_cnt[0] + done_cnt[1], 0);

`ifdef AES_CTRL_ABORT_EN
    // abort while waiting for a round key
    do_reset();
    start_i = 1; in_valid_i = 1;
    for (int k = 0; k < 40 && m_ph[0] != PH_KEY; k++) begin
      tick();
      start_i = 0;
    end
    if (m_ph[0] != PH_KEY) fail_now("abort.reach_kreq");
    abort_i = 1;
    tick();
    abort_i = 0;
    sample();
    chk("abort.aborted_o", int'(aborted_o[0]), 1);
    chk("abort.busy", int'(busy_o[0]), 0);
    chk("abort.done", int'(done_o[0]), 0);
    advance();
`endif

    // random stimulus against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start_i = ($urandom_range(7) == 0);
      in_valid_i = ($urandom_range(3) != 0);
      key_ack_i = ($urandom_range(2) == 0);
      sr_ready_i = 1'($urandom_range(1));
      out_ready_i = ($urandom_range(2) != 0);
`ifdef AES_CTRL_ABORT_EN
      abort_i = ($urandom_range(999) == 0);
`endif
      tick();
    end
    chk("rand.nr10.blocks_completed", int'(done_cnt[0] >= 2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
